adc_i2s_receiver: RTL and testbench

//  Receive side of the codec serial audio link. Deserialises AUD_ADCDAT (I2S, MSB first) from the

---
 rtl/adc_i2s_receiver.sv | 138 +++++++++++++
 tb/tb_adc_i2s_receiver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/adc_i2s_receiver.sv
// I2S ADC receiver: synchronises codec BCLK/LRCK/DAT into Clk, deserialises MSB-first
// left/right words and presents each complete pair on a valid/ready handshake.
module adc_i2s_receiver #(
  parameter int SAMPLE_BITS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic                   AUD_BCLK,
  input  logic                   AUD_ADCLRCK,
  input  logic                   AUD_ADCDAT,
  output logic [SAMPLE_BITS-1:0] LDATA_OUT,
  output logic [SAMPLE_BITS-1:0] RDATA_OUT,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  output logic                   frame_err
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SHIFT, S_WAIT} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, dat_sync_q;
  logic                   bclk_prev_q, lr_last_q;
  state_t                 state_q;
  logic                   chan_q;
  logic [CW-1:0]          bitcnt_q;
  logic [SAMPLE_BITS-1:0] shreg_q, left_hold_q, right_hold_q;
  logic                   left_ok_q, commit_q;
  logic [SAMPLE_BITS-1:0] ldata_q, rdata_q;
  logic                   valid_q, overrun_q, frame_err_q;

  logic                   bclk_s, lr_s, dat_s;
  logic                   bclk_rise, lr_edge;
  logic [SAMPLE_BITS-1:0] shreg_d;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lr_s      = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  // LRCK is only meaningful at BCLK sampling points, so its edge is qualified by a rise.
  assign lr_edge   = bclk_rise & (lr_s ^ lr_last_q);
  assign shreg_d   = {shreg_q[SAMPLE_BITS-2:0], dat_s};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      dat_sync_q   <= '0;
      bclk_prev_q  <= 1'b0;
      lr_last_q    <= 1'b0;
      state_q      <= S_IDLE;
      chan_q       <= 1'b0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      left_ok_q    <= 1'b0;
      commit_q     <= 1'b0;
      ldata_q      <= '0;
      rdata_q      <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_prev_q <= bclk_s;
      if (bclk_rise) lr_last_q <= lr_s;

      frame_err_q <= 1'b0;
      commit_q    <= 1'b0;

      if (!Enable) begin
        state_q   <= S_IDLE;
        left_ok_q <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        case (state_q)
          // The rise that reveals the LRCK change carries the I2S delay bit; SKIP drops it.
          S_IDLE, S_WAIT: begin
            if (lr_edge) begin
              chan_q  <= lr_s;
              state_q <= S_SKIP;
            end
          end
          S_SKIP: begin
            bitcnt_q <= '0;
            state_q  <= S_SHIFT;
          end
          S_SHIFT: begin
            if (lr_edge) begin
              frame_err_q <= 1'b1;
              if (!chan_q) left_ok_q <= 1'b0;
              chan_q  <= lr_s;
              state_q <= S_SKIP;
            end else if (bclk_rise) begin
              shreg_q  <= shreg_d;
              bitcnt_q <= bitcnt_q + 1'b1;
              if (bitcnt_q == CW'(SAMPLE_BITS - 1)) begin
                state_q <= S_WAIT;
                if (!chan_q) begin
                  left_hold_q <= shreg_d;
                  left_ok_q   <= 1'b1;
                end else if (left_ok_q) begin
                  right_hold_q <= shreg_d;
                  commit_q     <= 1'b1;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end

      // A commit wins over a same-cycle accept; it only counts as overrun if the old pair was not taken.
      if (commit_q && Enable) begin
        ldata_q   <= left_hold_q;
        rdata_q   <= right_hold_q;
        valid_q   <= 1'b1;
        left_ok_q <= 1'b0;
        overrun_q <= overrun_q | (valid_q & ~sample_ready);
      end else if (valid_q && sample_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign LDATA_OUT    = ldata_q;
  assign RDATA_OUT    = rdata_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_adc_i2s_receiver.sv
// Bench for adc_i2s_receiver: drives I2S frames (BCLK = Clk/8, 32-bit slots) and checks
// committed pairs against a scoreboard queue, plus status flags and latency.
module tb_adc_i2s_receiver;
  localparam int SYNC = 2;

  logic        Clk = 1'b0;
  logic        Reset, Enable, AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT, sample_ready;
  logic [15:0] LDATA_OUT, RDATA_OUT;
  logic        sample_valid, overrun, frame_err;

  int          checks = 0, errors = 0;
  int          cyc = 0, mark_cyc = 0, rise_cyc = 0, commits = 0, fe_cnt = 0;
  int          c0, f0;
  logic        valid_prev = 1'b0, fe_prev = 1'b0;
  logic [31:0] exp_q[$];
  event        r_done;

  adc_i2s_receiver #(.SAMPLE_BITS(16), .SYNC_STAGES(SYNC)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Enable       (Enable),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_ADCLRCK  (AUD_ADCLRCK),
    .AUD_ADCDAT   (AUD_ADCDAT),
    .LDATA_OUT    (LDATA_OUT),
    .RDATA_OUT    (RDATA_OUT),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard side: every accepted pair must match the oldest expected pair.
  always @(negedge Clk) begin
    if (sample_valid && !valid_prev) begin
      commits++;
      rise_cyc = cyc;
    end
    if (frame_err) begin
      fe_cnt++;
      chk("fe_width", {31'd0, fe_prev}, 32'd0);
    end
    if (sample_valid && sample_ready) begin
      if (exp_q.size() == 0) chk("spurious_pair", {31'd0, sample_valid}, 32'd0);
      else chk("pair", {LDATA_OUT, RDATA_OUT}, exp_q.pop_front());
    end
    valid_prev = sample_valid;
    fe_prev    = frame_err;
  end

  task automatic bclk_cycle(input logic lr, input logic d, input bit mark);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    repeat (4) @(posedge Clk);
    #1;
    AUD_BCLK = 1'b1;
    if (mark) begin
      mark_cyc = cyc;
      ->r_done;
    end
    repeat (4) @(posedge Clk);
    #1;
  endtask

  // Slot index 0 is the I2S delay bit, 1..16 carry the word MSB first, the rest are padding.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++)
      bclk_cycle(lr, (i >= 1 && i <= 16) ? w[16-i] : 1'b0, lr && (i == 16));
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 0, 32);
    send_slot(1'b1, r, 0, 32);
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; sample_ready = 1'b1;
    AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ldata", LDATA_OUT, 0);
    chk("rst_rdata", RDATA_OUT, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    @(posedge Clk); #1;
    Reset = 1'b0; Enable = 1'b1;

    // Basic pair; the leading right slot has no left partner and is dropped.
    send_slot(1'b1, 16'hFFFF, 0, 32);
    exp_q.push_back(32'h1234ABCD);
    send_pair(16'h1234, 16'hABCD);
    chk("t1_latency", rise_cyc - mark_cyc, SYNC + 2);
    chk("t1_pulses", commits, 1);
    chk("t1_valid_low", sample_valid, 0);

    // Overrun: two pairs while the consumer stalls; only the second survives.
    sample_ready = 1'b0;
    send_pair(16'h0001, 16'h0002);
    exp_q.push_back(32'h00030004);
    send_pair(16'h0003, 16'h0004);
    chk("t2_ldata", LDATA_OUT, 16'h0003);
    chk("t2_rdata", RDATA_OUT, 16'h0004);
    chk("t2_valid", sample_valid, 1);
    chk("t2_overrun", overrun, 1);
    Enable = 1'b0;
    repeat (2) @(posedge Clk); #1;
    chk("t2_ovr_cleared", overrun, 0);
    chk("t2_valid_kept", sample_valid, 1);
    Enable = 1'b1;
    @(posedge Clk); #1;
    chk("t2_ovr_reenabled", overrun, 0);
    sample_ready = 1'b1;
    repeat (3) @(posedge Clk); #1;
    chk("t2_valid_drop", sample_valid, 0);

    // Short left word: frame error, no commit, then a clean frame.
    c0 = commits; f0 = fe_cnt;
    send_slot(1'b0, 16'h1234, 0, 11);
    send_slot(1'b1, 16'h5A5A, 0, 32);
    chk("t3_frame_err", fe_cnt - f0, 1);
    chk("t3_no_commit", commits - c0, 0);
    exp_q.push_back(32'h80007FFF);
    send_pair(16'h8000, 16'h7FFF);
    chk("t3_commit", commits - c0, 1);

    // Commit lands in the same cycle as the accept of the previous pair.
    sample_ready = 1'b0;
    exp_q.push_back(32'h0A0A0B0B);
    send_pair(16'h0A0A, 16'h0B0B);
    exp_q.push_back(32'h0C0C0D0D);
    fork
      send_pair(16'h0C0C, 16'h0D0D);
      begin
        @(r_done);
        repeat (3) @(posedge Clk);
        #1 sample_ready = 1'b1;
        @(negedge Clk);
        chk("t4_old_valid", sample_valid, 1);
        @(negedge Clk);
        chk("t4_new_valid", sample_valid, 1);
        chk("t4_new_ldata", LDATA_OUT, 16'h0C0C);
      end
    join
    chk("t4_overrun", overrun, 0);
    chk("t4_valid_drop", sample_valid, 0);

    // Reset in the middle of a right word.
    send_slot(1'b0, 16'h1111, 0, 32);
    send_slot(1'b1, 16'h2222, 0, 10);
    Reset = 1'b1;
    repeat (2) @(posedge Clk); #1;
    chk("t5_ldata", LDATA_OUT, 0);
    chk("t5_rdata", RDATA_OUT, 0);
    chk("t5_valid", sample_valid, 0);
    Reset = 1'b0;
    send_slot(1'b1, 16'h2222, 10, 22);
    exp_q.push_back(32'h24681357);
    send_pair(16'h2468, 16'h1357);

    // Disable mid-frame; after re-enable a right-first word must not pair with the stale left.
    send_slot(1'b0, 16'hAAAA, 0, 32);
    send_slot(1'b1, 16'h0F0F, 0, 8);
    Enable = 1'b0;
    send_slot(1'b1, 16'h0F0F, 8, 24);
    send_slot(1'b0, 16'h0000, 0, 5);
    Enable = 1'b1;
    send_slot(1'b0, 16'h0000, 5, 27);
    send_slot(1'b1, 16'hBBBB, 0, 32);
    c0 = commits;
    exp_q.push_back(32'hCAFEBEEF);
    send_pair(16'hCAFE, 16'hBEEF);
    chk("t6_commit", commits - c0, 1);

    repeat (10) @(posedge Clk); #1;
    chk("sb_empty", exp_q.size(), 0);
    chk("fe_total", fe_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
